// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared definitions for the core's elastic pipeline stage registers
//
// Purpose : state encodings for the 2-entry skid-buffer stage, payload widths of
//           the stage boundaries, and a helper mapping a state to its entry count.
// Ports   : none (package)

package pipe_pkg;

  // Stage state; the encoding equals the number of held entries.
  typedef logic [1:0] pipe_state_t;

  localparam logic [1:0] PIPE_ST_EMPTY = 2'd0;  // nothing held
  localparam logic [1:0] PIPE_ST_HALF  = 2'd1;  // main register only
  localparam logic [1:0] PIPE_ST_FULL  = 2'd2;  // main + skid registers

  // Payload widths of the core's stage boundaries.
  localparam int IF_ID_W  = 134;
  localparam int ID_EX_W  = 173;
  localparam int EX_MEM_W = 106;

  // Entries held in a given state; unused encodings report empty.
  function automatic logic [1:0] pipe_state_count(input pipe_state_t st);
    logic [1:0] cnt;
    case (st)
      PIPE_ST_HALF: cnt = 2'd1;
      PIPE_ST_FULL: cnt = 2'd2;
      default:      cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter for pipeline stage statistics
//
// Purpose : counts cycles with inc high, sticking at all-ones; cleared by reset.
// Ports   : clk   in  1      rising-edge clock
//           reset in  1      synchronous, active-high clear
//           inc   in  1      count this cycle
//           count out CNT_W  current count (registered)

module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stage_buffer.sv
// rtl/pipeline_stage_buffer.sv - elastic valid/ready pipeline register with 2-entry skid buffer
//
// Purpose : stage register between core pipeline stages. Full throughput, one
//           cycle in->out latency, strict FIFO order, flush on redirect. in_ready
//           depends only on the state flop (and reset), so no ready chain forms
//           through consecutive stages.
// Build   : define PIPE_STAGE_STATS_EN to add the stall_count / flush_count ports.
// Ports   : clk         in  1       rising-edge clock
//           reset       in  1       synchronous, active-high reset
//           flush       in  1       discard all held entries (redirect)
//           in_valid    in  1       upstream payload valid
//           in_ready    out 1       stage can accept this cycle
//           in_data     in  DATA_W  upstream payload
//           out_valid   out 1       out_data holds a valid entry
//           out_ready   in  1       downstream accepts this cycle
//           out_data    out DATA_W  oldest held entry (main register)
//           occupancy   out 2       entries held: 0, 1 or 2
//           stall_count out CNT_W   [stats] cycles with out_valid & !out_ready
//           flush_count out CNT_W   [stats] cycles with flush asserted

module pipeline_stage_buffer
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 134,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q,  main_d;
  logic [DATA_W-1:0] skid_q,  skid_d;

  logic in_fire;
  logic out_fire;

  // Ready is a pure function of the state flop; reset only forces it low.
  assign in_ready  = (state_q != PIPE_ST_FULL) && !reset;
  assign out_valid = (state_q != PIPE_ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = pipe_state_count(state_q);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Redirect: drop everything, including a beat accepted this cycle.
      // A beat leaving this cycle is still delivered; downstream sees the
      // same flush and decides what to do with it.
      state_d = PIPE_ST_EMPTY;
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end else begin
      case (state_q)
        PIPE_ST_EMPTY: begin
          if (in_fire) begin
            state_d = PIPE_ST_HALF;
            main_d  = in_data;
          end
        end

        PIPE_ST_HALF: begin
          if (in_fire && out_fire) begin
            // Pass-through: the new beat replaces the one leaving.
            main_d = in_data;
          end else if (in_fire) begin
            // Downstream stalled while we had said ready: park the beat.
            state_d = PIPE_ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = PIPE_ST_EMPTY;
          end
        end

        PIPE_ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_d = PIPE_ST_HALF;
            main_d  = skid_q;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_d = PIPE_ST_EMPTY;
          main_d  = RESET_DATA;
          skid_d  = RESET_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PIPE_ST_EMPTY;
      main_q  <= RESET_DATA;
      skid_q  <= RESET_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic stall_inc;

  assign stall_inc = out_valid && !out_ready;

  // Only reset clears the counters; flush does not.
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_count)
  );
`else
  // CNT_W only sizes the statistics counters, which this build leaves out.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// tb/tb_pipeline_stage_buffer.sv - self-checking bench for pipeline_stage_buffer

module tb_pipeline_stage_buffer;

  localparam int DW = 134;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam logic [DW-1:0] RST_D = 134'h3C3C_0000_1234;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;
`endif

  always #5 clk = ~clk;

  pipeline_stage_buffer #(
    .DATA_W     (DW),
    .RESET_DATA (RST_D),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_count (stall_count),
    .flush_count (flush_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the stage is a FIFO of capacity 2.
  logic [DW-1:0] q[$];
  logic [DW-1:0] emitted[$];
  int            stall_m;
  int            flush_m;
  logic [159:0]  rnd;
  int            hits;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks outputs against the model, then advances one clock edge.
  task automatic cycle(input string tag);
    bit ir, ov, inf, outf;
    #1;
    ir = (q.size() < 2) && !reset;
    ov = (q.size() > 0);
    chk({tag, ":in_ready"},  DW'(in_ready),  DW'(ir));
    chk({tag, ":out_valid"}, DW'(out_valid), DW'(ov));
    chk({tag, ":occupancy"}, DW'(occupancy), DW'(q.size()));
    if (ov) chk({tag, ":out_data"}, out_data, q[0]);
`ifdef PIPE_STAGE_STATS_EN
    chk({tag, ":stall_count"}, DW'(stall_count), DW'(stall_m));
    chk({tag, ":flush_count"}, DW'(flush_count), DW'(flush_m));
`endif
    inf  = in_valid && ir;
    outf = ov && out_ready;
    if (outf) emitted.push_back(out_data);
    @(posedge clk);
    if (reset) begin
      q.delete();
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (ov && !out_ready && stall_m < CNT_MAX) stall_m++;
      if (flush && flush_m < CNT_MAX) flush_m++;
      if (flush) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(in_data);
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    stall_m = 0; flush_m = 0;

    // 1. reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst:out_valid", DW'(out_valid), DW'(0));
    chk("rst:in_ready",  DW'(in_ready),  DW'(0));
    chk("rst:occupancy", DW'(occupancy), DW'(0));
    chk("rst:out_data",  out_data,       RST_D);
    reset = 1'b0;
    #1;
    chk("rel:in_ready", DW'(in_ready), DW'(1));

    // 2. back-to-back stream with downstream always ready
    emitted.delete();
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(k);
      cycle("t2");
    end
    in_valid = 1'b0;
    cycle("t2_tail");
    cycle("t2_idle");
    chk("t2:count", DW'(emitted.size()), DW'(3));
    for (int k = 0; k < 3 && k < emitted.size(); k++) chk("t2:order", emitted[k], DW'(k + 1));

    // 3. fill while stalled, then drain
    emitted.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(134'hA);
    cycle("t3_pushA");
    in_data   = DW'(134'hB);
    cycle("t3_pushB");
    in_valid  = 1'b0;
    chk("t3:occupancy", DW'(occupancy), DW'(2));
    chk("t3:in_ready",  DW'(in_ready),  DW'(0));
    cycle("t3_full");
    out_ready = 1'b1;
    cycle("t3_popA");
    chk("t3:ready_after_pop", DW'(in_ready), DW'(1));
    cycle("t3_popB");
    cycle("t3_empty");
    chk("t3:count", DW'(emitted.size()), DW'(2));
    if (emitted.size() == 2) begin
      chk("t3:first",  emitted[0], DW'(134'hA));
      chk("t3:second", emitted[1], DW'(134'hB));
    end

    // 4. flush while full with a new beat offered
    emitted.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(134'hC);
    cycle("t4_pushC");
    in_data   = DW'(134'hD);
    cycle("t4_pushD");
    in_data   = DW'(134'hE);
    flush     = 1'b1;
    cycle("t4_flush");
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t4:occupancy", DW'(occupancy), DW'(0));
    chk("t4:out_valid", DW'(out_valid), DW'(0));
    repeat (3) cycle("t4_after");
    hits = 0;
    foreach (emitted[i]) begin
      if (emitted[i] == DW'(134'hC) || emitted[i] == DW'(134'hD) || emitted[i] == DW'(134'hE)) hits++;
    end
    chk("t4:leak", DW'(hits), DW'(0));

    // 5. simultaneous push and pop while half full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(134'h5);
    cycle("t5_push5");
    in_data   = DW'(134'h6);
    out_ready = 1'b1;
    cycle("t5_swap");
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5:occupancy", DW'(occupancy), DW'(1));
    chk("t5:out_data",  out_data,       DW'(134'h6));
    cycle("t5_hold");

    // Randomised traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rnd       = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_data   = rnd[DW-1:0];
      cycle("rnd");
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle("rnd_drain");

`ifdef PIPE_STAGE_STATS_EN
    // 6. saturating statistics
    reset = 1'b1;
    cycle("t6_reset");
    reset     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(134'h7);
    cycle("t6_push");
    in_valid  = 1'b0;
    repeat (5) cycle("t6_stall");
    chk("t6:stall_sat", DW'(stall_count), DW'(3));
    for (int p = 0; p < 3; p++) begin
      flush = 1'b1;
      cycle("t6_flush");
      flush = 1'b0;
      cycle("t6_gap");
    end
    chk("t6:flush_cnt", DW'(flush_count), DW'(3));
    reset = 1'b1;
    cycle("t6_clear");
    reset = 1'b0;
    chk("t6:stall_clr", DW'(stall_count), DW'(0));
    chk("t6:flush_clr", DW'(flush_count), DW'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
